// File: rtl/col2img_if.sv
// col2img stream interface.
// The column-element input stream and the finished-image output handshake.
// slave: the col2img block. master: the element source and the image consumer.
interface col2img_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int IMG_DIM    = 5
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_WIDTH-1:0]  out_img [IMG_DIM][IMG_DIM];
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_img, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_img, out_valid
  );
endinterface

// File: rtl/col2img.sv
// col2img: scatters an img2col-ordered column stream back onto an
// IMG_DIM x IMG_DIM image, overlap-adding elements from overlapping patches.
// The finished image is held on out_img with out_valid until out_ready.
//
// Build option: define COL2IMG_SAT_EN to make every accumulate saturate at
// 2^ACC_WIDTH-1. Without it the accumulators wrap modulo 2^ACC_WIDTH.
//
// state | meaning
// IDLE  | waiting for start; image from the last frame still visible
// ACCUM | accepting elements and overlap-adding them into the image
// DONE  | image complete, out_valid high until out_ready
//
// k is three bits wide, so IMG_DIM is expected to be at most 7.
module col2img #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int IMG_DIM    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] k,
  input  logic       stride,
  output logic       busy,
  output logic       err,
  col2img_if.slave   bus
);

  typedef logic [ACC_WIDTH-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [2:0] DIM3 = 3'(IMG_DIM);

  state_t     state_q, state_d;
  logic [2:0] k_q;
  logic       s_q;
  logic [2:0] pr_q, pc_q, er_q, ec_q;
  acc_t       acc [IMG_DIM][IMG_DIM];
  logic       err_q;

  logic       k_ok, start_ok, hs;
  logic [2:0] span, p_last, k_last;
  logic       ec_last, er_last, pc_last, pr_last, frame_last;
  logic [3:0] row, col;

  // One accumulate step; saturating only when the build option is set.
  function automatic acc_t acc_add(input acc_t a, input acc_t b);
`ifdef COL2IMG_SAT_EN
    logic [ACC_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  assign k_ok     = (k != 3'd0) && (k <= DIM3);
  assign start_ok = (state_q == IDLE) && start && k_ok;

  // Last patch index is (IMG_DIM-k)/s; s is 1 or 2 so the divide is a shift.
  assign span   = DIM3 - k_q;
  assign p_last = s_q ? {1'b0, span[2:1]} : span;
  assign k_last = k_q - 3'd1;

  assign ec_last    = (ec_q == k_last);
  assign er_last    = (er_q == k_last);
  assign pc_last    = (pc_q == p_last);
  assign pr_last    = (pr_q == p_last);
  assign frame_last = ec_last && er_last && pc_last && pr_last;

  // Target pixel of the current element: patch origin (scaled by stride) plus offset.
  assign row = ({1'b0, pr_q} << s_q) + {1'b0, er_q};
  assign col = ({1'b0, pc_q} << s_q) + {1'b0, ec_q};

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    busy         = 1'b0;
    hs           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        hs           = bus.in_valid;
        if (hs && frame_last) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Config latch and patch/element counters (ec fastest, pr slowest).
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= 3'd0;
      s_q  <= 1'b0;
      pr_q <= 3'd0;
      pc_q <= 3'd0;
      er_q <= 3'd0;
      ec_q <= 3'd0;
    end else if (start_ok) begin
      k_q  <= k;
      s_q  <= stride;
      pr_q <= 3'd0;
      pc_q <= 3'd0;
      er_q <= 3'd0;
      ec_q <= 3'd0;
    end else if (hs) begin
      if (!ec_last) begin
        ec_q <= ec_q + 3'd1;
      end else begin
        ec_q <= 3'd0;
        if (!er_last) begin
          er_q <= er_q + 3'd1;
        end else begin
          er_q <= 3'd0;
          if (!pc_last) begin
            pc_q <= pc_q + 3'd1;
          end else begin
            pc_q <= 3'd0;
            pr_q <= pr_last ? 3'd0 : pr_q + 3'd1;
          end
        end
      end
    end
  end

  // Accumulator array: cleared by reset or a legal start, overlap-add on handshake.
  always_ff @(posedge clk) begin
    for (int r = 0; r < IMG_DIM; r++) begin
      for (int c = 0; c < IMG_DIM; c++) begin
        if (rst || start_ok) begin
          acc[r][c] <= '0;
        end else if (hs && (int'(row) == r) && (int'(col) == c)) begin
          acc[r][c] <= acc_add(acc[r][c], acc_t'(bus.in_data));
        end
      end
    end
  end

  // Single-cycle error pulse for a start with an out-of-range kernel size.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == IDLE) && start && !k_ok;
  end

  assign err         = err_q;
  assign bus.out_img = acc;

endmodule

// File: tb/tb_col2img.sv
// Directed bench for col2img, built with ACC_WIDTH=8 so the overflow frame
// exercises wrap/saturation; expectations follow COL2IMG_SAT_EN if defined.
module tb_col2img;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int DIM = 5;

`ifdef COL2IMG_SAT_EN
  localparam int E00_OVF = 200;
  localparam int E01_OVF = 255;
  localparam int E12_OVF = 255;
  localparam int E22_OVF = 255;
`else
  localparam int E00_OVF = 200;
  localparam int E01_OVF = 144;   // 400 mod 256
  localparam int E12_OVF = 176;   // 1200 mod 256
  localparam int E22_OVF = 8;     // 1800 mod 256
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] k;
  logic       stride;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  col2img_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMG_DIM(DIM)) bus ();

  col2img #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMG_DIM(DIM)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .k      (k),
    .stride (stride),
    .busy   (busy),
    .err    (err),
    .bus    (bus)
  );

  typedef struct {
    int kk;
    int ss;
    int mode;    // 0: every element = value, 1: element = its index
    int value;
  } frame_t;

  typedef struct {
    int frame;
    int r;
    int c;
    int exp;
  } pix_t;

  frame_t frames [3];
  pix_t   pixs   [18];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic start_frame(input int kk, input int ss);
    start  = 1'b1;
    k      = 3'(kk);
    stride = ss[0];
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Streams a frame; limit >= 0 stops after that many elements (no DONE checks).
  task automatic run_frame(input int kk, input int ss, input int mode,
                           input int value, input int gaps, input int limit);
    int p, n;
    p = (DIM - kk) / (ss != 0 ? 2 : 1) + 1;
    n = p * p * kk * kk;
    if (limit >= 0) n = limit;
    start_frame(kk, ss);
    for (int i = 0; i < n; i++) begin
      if (gaps != 0) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'hFF;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(mode != 0 ? i : value);
      if (i == n - 1 && limit < 0) begin
        check("out_valid before last", bus.out_valid, 0);
        check("in_ready before last", bus.in_ready, 1);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    if (limit < 0) begin
      check("out_valid after last", bus.out_valid, 1);
      check("in_ready in DONE", bus.in_ready, 0);
      check("busy in DONE", busy, 1);
    end
  endtask

  task automatic ack_image();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid after ack", bus.out_valid, 0);
    check("busy after ack", busy, 0);
  endtask

  task automatic err_case(input int kk);
    start = 1'b1;
    k     = 3'(kk);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("err pulse k=%0d", kk), err, 1);
    check($sformatf("busy err k=%0d", kk), busy, 0);
    check($sformatf("in_ready err k=%0d", kk), bus.in_ready, 0);
    @(negedge clk);
    check($sformatf("err drop k=%0d", kk), err, 0);
    check($sformatf("idle after err k=%0d", kk), busy, 0);
  endtask

  initial begin
    int nz;

    frames[0] = '{kk: 3, ss: 0, mode: 0, value: 1};
    frames[1] = '{kk: 2, ss: 1, mode: 0, value: 1};
    frames[2] = '{kk: 5, ss: 0, mode: 1, value: 0};

    pixs[0]  = '{frame: 0, r: 0, c: 0, exp: 1};
    pixs[1]  = '{frame: 0, r: 0, c: 1, exp: 2};
    pixs[2]  = '{frame: 0, r: 1, c: 1, exp: 4};
    pixs[3]  = '{frame: 0, r: 2, c: 2, exp: 9};
    pixs[4]  = '{frame: 0, r: 4, c: 4, exp: 1};
    pixs[5]  = '{frame: 0, r: 0, c: 2, exp: 3};
    pixs[6]  = '{frame: 0, r: 2, c: 4, exp: 3};
    pixs[7]  = '{frame: 1, r: 0, c: 0, exp: 1};
    pixs[8]  = '{frame: 1, r: 3, c: 3, exp: 1};
    pixs[9]  = '{frame: 1, r: 4, c: 0, exp: 0};
    pixs[10] = '{frame: 1, r: 0, c: 4, exp: 0};
    pixs[11] = '{frame: 1, r: 4, c: 4, exp: 0};
    pixs[12] = '{frame: 1, r: 2, c: 3, exp: 1};
    pixs[13] = '{frame: 2, r: 0, c: 0, exp: 0};
    pixs[14] = '{frame: 2, r: 1, c: 2, exp: 7};
    pixs[15] = '{frame: 2, r: 4, c: 4, exp: 24};
    pixs[16] = '{frame: 2, r: 3, c: 0, exp: 15};
    pixs[17] = '{frame: 2, r: 2, c: 4, exp: 14};

    rst           = 1'b1;
    start         = 1'b0;
    k             = 3'd0;
    stride        = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    nz = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (bus.out_img[r][c] != 0) nz++;
    check("reset image nonzero count", nz, 0);
    check("reset in_ready", bus.in_ready, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", busy, 0);
    check("reset err", err, 0);

    err_case(0);
    err_case(6);

    for (int f = 0; f < 3; f++) begin
      run_frame(frames[f].kk, frames[f].ss, frames[f].mode, frames[f].value, 0, -1);
      for (int j = 0; j < 18; j++) begin
        if (pixs[j].frame == f)
          check($sformatf("frame%0d px[%0d][%0d]", f, pixs[j].r, pixs[j].c),
                bus.out_img[pixs[j].r][pixs[j].c], pixs[j].exp);
      end
      ack_image();
    end

    // k=3 stride 2 with random gaps, then a stalled consumer.
    run_frame(3, 1, 0, 3, 1, -1);
    check("gap px[2][2]", bus.out_img[2][2], 12);
    check("gap px[0][0]", bus.out_img[0][0], 3);
    check("gap px[2][0]", bus.out_img[2][0], 6);
    check("gap px[1][3]", bus.out_img[1][3], 3);
    check("gap px[4][4]", bus.out_img[4][4], 3);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      k     = 3'd2;
      @(negedge clk);
      check("hold out_valid", bus.out_valid, 1);
      check("hold in_ready", bus.in_ready, 0);
      check("hold busy", busy, 1);
      check("hold px[2][2]", bus.out_img[2][2], 12);
    end
    start = 1'b0;
    ack_image();
    check("retained px[2][2]", bus.out_img[2][2], 12);

    // Overflow frame interrupted by reset, then rerun to completion.
    run_frame(3, 0, 0, 200, 0, 40);
    check("partial px[0][0]", bus.out_img[0][0], 200);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nz = 0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        if (bus.out_img[r][c] != 0) nz++;
    check("mid-frame reset nonzero count", nz, 0);
    check("mid-frame reset busy", busy, 0);
    check("mid-frame reset in_ready", bus.in_ready, 0);

    run_frame(3, 0, 0, 200, 0, -1);
    check("ovf px[0][0]", bus.out_img[0][0], E00_OVF);
    check("ovf px[0][1]", bus.out_img[0][1], E01_OVF);
    check("ovf px[1][2]", bus.out_img[1][2], E12_OVF);
    check("ovf px[2][2]", bus.out_img[2][2], E22_OVF);
    check("ovf px[4][4]", bus.out_img[4][4], 200);
    ack_image();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
